// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the transmitter and receiver.
// Holds the slot/frame geometry, the word-select polarity and a helper
// that sizes the in-frame bit counter.
package i2s_pkg;

    localparam int SLOT_BITS_DEF = 32;
    localparam int FRAME_BITS    = 2 * SLOT_BITS_DEF;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    // Width of a counter that walks every bit position of one frame.
    function automatic int bit_cnt_width(input int slot_bits);
        return $clog2(2 * slot_bits);
    endfunction

    localparam int BIT_CNT_W = bit_cnt_width(SLOT_BITS_DEF);

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit-clock generator: divides clk into sclk, walks the frame bit
// counter and flags the cycle in which sclk falls.
// fall and bit_next are combinational and describe the coming edge, so a
// user can update its serial outputs on that same edge as sclk drops.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int SCLK_DIV  = 16,
    parameter int SLOT_BITS = SLOT_BITS_DEF,
    parameter int BIT_W     = bit_cnt_width(SLOT_BITS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             sclk,
    output logic             fall,
    output logic [BIT_W-1:0] bit_next
);

    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             wrap;

    assign wrap     = (div_cnt == DIV_LAST);
    assign fall     = wrap && sclk;
    assign bit_next = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;

    // Divider, sclk toggle and frame bit position (advanced on each fall).
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            bit_cnt <= BIT_LAST;
        end else begin
            if (wrap) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (fall) begin
                bit_cnt <= bit_next;
            end
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: plays one mono sample per frame on both
// channels (Philips format, ws one bit ahead of data, MSB first).
// Optional macro I2S_TX_ZERO_ON_UNDERRUN_EN: an underrun frame plays 0
// instead of repeating the last sample.
//
// Input handshake: a sample transfers on a clk edge where valid_in and
// ready_out are both high; ready_out is the registered "holding empty"
// flag and never depends on valid_in in the same cycle.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int SCLK_DIV  = 16,
    parameter int SLOT_BITS = SLOT_BITS_DEF
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             sclk_out,
    output logic             ws_out,
    output logic             sdata_out,
    output logic             underrun_out
);

    localparam int BIT_W = bit_cnt_width(SLOT_BITS);
    localparam logic [BIT_W-1:0] SLOT_N    = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] SLOT_LAST = BIT_W'(SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] WS_END    = BIT_W'(2 * SLOT_BITS - 2);
    localparam logic [BIT_W-1:0] WIDTH_N   = BIT_W'(WIDTH);

    logic             fall;
    logic [BIT_W-1:0] bit_next;

    logic [WIDTH-1:0] holding;
    logic             holding_valid;
    logic [WIDTH-1:0] frame_word;   // also the last played sample

    logic             frame_start;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] word_now;
    logic [WIDTH-1:0] shifted;
    logic [BIT_W-1:0] slot_bit;
    logic             sdata_next;
    logic             ws_next;

    i2s_clkgen #(
        .SCLK_DIV (SCLK_DIV),
        .SLOT_BITS(SLOT_BITS),
        .BIT_W    (BIT_W)
    ) u_clkgen (
        .clk     (clk_in),
        .rst     (rst_in),
        .sclk    (sclk_out),
        .fall    (fall),
        .bit_next(bit_next)
    );

    assign ready_out = !holding_valid;

    // Next serial bit and word select for the bit position entered on this fall.
    always_comb begin
        frame_start = fall && (bit_next == '0);
`ifdef I2S_TX_ZERO_ON_UNDERRUN_EN
        load_word   = holding_valid ? holding : '0;
`else
        load_word   = holding_valid ? holding : frame_word;
`endif
        word_now    = frame_start ? load_word : frame_word;
        slot_bit    = (bit_next >= SLOT_N) ? bit_next - SLOT_N : bit_next;
        shifted     = word_now << slot_bit;
        sdata_next  = (slot_bit < WIDTH_N) ? shifted[WIDTH-1] : 1'b0;
        ws_next     = ((bit_next >= SLOT_LAST) && (bit_next <= WS_END)) ? WS_RIGHT : WS_LEFT;
    end

    // Holding register, frame word load and registered serial outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            holding       <= '0;
            holding_valid <= 1'b0;
            frame_word    <= '0;
            ws_out        <= WS_LEFT;
            sdata_out     <= 1'b0;
            underrun_out  <= 1'b0;
        end else begin
            underrun_out <= 1'b0;
            if (fall) begin
                ws_out    <= ws_next;
                sdata_out <= sdata_next;
            end
            if (frame_start) begin
                frame_word   <= load_word;
                underrun_out <= !holding_valid;
            end
            // A load frees the holding register; an accept can only happen
            // while it is already empty, so the two never collide.
            if (frame_start && holding_valid) begin
                holding_valid <= 1'b0;
            end else if (valid_in && !holding_valid) begin
                holding       <= sample_in;
                holding_valid <= 1'b1;
            end
        end
    end

endmodule
